shift_xfer_ctrl: RTL

Transfer controller that sequences a universal shift register for full-duplex serial exchange of one N-bit word.
- Command side: accepts a word and a direction over a valid/ready handshake.
- Serial side: loads the register, then shifts N times, driving sout and capturing sin, paced by a shift-enable tick.
- Response side: returns the captured word over a second valid/ready handshake.
- Placement: between a parallel host and a bit-serial link.

---
 rtl/shift_xfer_pkg.sv | 17 +
 rtl/ushift_reg.sv | 31 +++
 rtl/shift_xfer_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/shift_xfer_pkg.sv
// Shared encodings for the shift transfer controller: FSM states,
// universal shift register mode codes and serial direction constants.
package shift_xfer_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [1:0] HOLD  = 2'b00;
    localparam logic [1:0] SHR   = 2'b01;
    localparam logic [1:0] SHL   = 2'b10;
    localparam logic [1:0] LOAD  = 2'b11;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/ushift_reg.sv
// N-bit universal shift register: hold, shift right, shift left or
// parallel load, with an asynchronous active-low clear.
module ushift_reg
    import shift_xfer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   s,
    input  logic [N-1:0] d,
    input  logic         Lin,
    input  logic         Rin,
    output logic [N-1:0] q
);

    // Lin feeds the MSB on a right shift, Rin feeds the LSB on a left shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            case (s)
                SHR:     q <= {Lin, q[N-1:1]};
                SHL:     q <= {q[N-2:0], Rin};
                LOAD:    q <= d;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_xfer_ctrl.sv
// Full-duplex serial word exchange: accepts a command word, shifts it out
// while capturing sin, then returns the captured word on a response handshake.
module shift_xfer_ctrl
    import shift_xfer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_dir,
    input  logic [N-1:0] cmd_data,
    input  logic         shift_en,
    input  logic         sin,
    output logic         sout,
    output logic         sout_valid,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         busy
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [1:0]       state;
    logic             dir;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode;
    logic [N-1:0]     q;

    ushift_reg #(.N(N)) u_sreg (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (mode),
        .d     (cmd_data),
        .Lin   (sin),
        .Rin   (sin),
        .q     (q)
    );

    always_comb begin
        mode = HOLD;
        case (state)
            IDLE:    if (cmd_valid) mode = LOAD;
            SHIFT:   if (shift_en) mode = (dir == DIR_MSB_FIRST) ? SHL : SHR;
            default: mode = HOLD;
        endcase
    end

    // The final shift (cnt == N-1) leaves cnt untouched and moves to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dir   <= DIR_LSB_FIRST;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir   <= cmd_dir;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (cnt == CNT_LAST) state <= RESP;
                        else                 cnt   <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        sout_valid = (state == SHIFT);
        rsp_valid  = (state == RESP);
        rsp_data   = (state == RESP) ? q : '0;
        sout       = 1'b0;
        if (state == SHIFT) sout = (dir == DIR_MSB_FIRST) ? q[N-1] : q[0];
    end

endmodule
